// File: rtl/product_bcd_display_pkg.sv
// rtl/product_bcd_display_pkg.sv - shared types, constants and double-dabble step for product_bcd_display
package product_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 5;
    localparam int SHIFT_CNT  = 16;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left by one
    function automatic logic [35:0] dd_step(input logic [35:0] w);
        logic [35:0] t;
        t = w;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5) begin
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/product_bcd_display_seg7_decode.sv
// rtl/product_bcd_display_seg7_decode.sv - BCD digit to active-low 7-segment pattern
module seg7_decode
    import product_bcd_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Blank overrides the digit; codes above 9 never occur but decode as blank
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/product_bcd_display.sv
// rtl/product_bcd_display.sv - multiplier product to BCD converter with multiplexed 7-segment scan
module product_bcd_display
    import product_bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_flag,
    input  logic [15:0] d_in,
    output logic        busy,
    output logic        bcd_valid,
    output logic [19:0] bcd,
    output logic [7:0]  seg_data,
    output logic [4:0]  seg_sel
);

    localparam int REF_W = $clog2(REFRESH_DIV);

    state_t            r_state;
    logic              r_done_q;
    logic              r_pending;
    logic              r_busy;
    logic              r_valid;
    logic [19:0]       r_bcd;
    logic [35:0]       r_work;
    logic [3:0]        r_cnt;
    logic [REF_W-1:0]  r_ref;
    logic [2:0]        r_idx;
    logic [4:0]        r_sel;
    logic [7:0]        r_seg;

    logic              w_start;
    logic [35:0]       w_work_next;
    logic [4:0]        w_blank;
    logic [3:0]        w_digit;
    logic [7:0]        w_pattern;
    logic              w_wrap;

    assign w_start     = done_flag & ~r_done_q;
    assign w_work_next = dd_step(r_work);
    assign w_wrap      = (r_ref == REF_W'(REFRESH_DIV - 1));

    assign busy      = r_busy;
    assign bcd_valid = r_valid;
    assign bcd       = r_bcd;
    assign seg_sel   = r_sel;
    assign seg_data  = r_seg;

    // Conversion FSM: edge detect, one-deep pending request, double-dabble datapath, result commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_done_q  <= 1'b0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
        end else begin
            r_done_q <= done_flag;
            r_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start || r_pending) begin
                        r_work    <= {20'b0, d_in};
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_start) begin
                        r_pending <= 1'b1;
                    end
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == 4'(SHIFT_CNT - 1)) begin
                        r_bcd   <= w_work_next[35:16];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A queued request reloads straight away; a fresh edge here is queued instead
                    if (r_pending) begin
                        r_work    <= {20'b0, d_in};
                        r_cnt     <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        if (w_start) begin
                            r_pending <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Leading-zero blanking: a digit blanks only if it and every higher digit are zero; units never blank
    always_comb begin
        w_blank    = '0;
        w_blank[4] = BLANK_LZ && (r_bcd[19:16] == 4'd0);
        w_blank[3] = w_blank[4] && (r_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
    end

    // Select the committed digit addressed by the scan index
    always_comb begin
        w_digit = r_bcd[3:0];
        case (r_idx)
            3'd0:    w_digit = r_bcd[3:0];
            3'd1:    w_digit = r_bcd[7:4];
            3'd2:    w_digit = r_bcd[11:8];
            3'd3:    w_digit = r_bcd[15:12];
            3'd4:    w_digit = r_bcd[19:16];
            default: w_digit = r_bcd[3:0];
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .i_blank (w_blank[r_idx]),
        .o_seg   (w_pattern)
    );

    // Display scan: refresh divider, digit index and registered segment drive updated on each wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref <= '0;
            r_idx <= '0;
            r_sel <= 5'b11111;
            r_seg <= SEG_BLANK;
        end else begin
            if (w_wrap) begin
                r_ref <= '0;
                r_sel <= ~(5'b00001 << r_idx);
                r_seg <= w_pattern;
                r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// tb/tb_product_bcd_display.sv - self-checking bench for product_bcd_display
module tb_product_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done_flag = 1'b0;
    logic [15:0] d_in = 16'h0;
    logic        busy, busy0;
    logic        bcd_valid, bcd_valid0;
    logic [19:0] bcd, bcd0;
    logic [7:0]  seg_data, seg_data0;
    logic [4:0]  seg_sel, seg_sel0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    product_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .done_flag(done_flag), .d_in(d_in),
        .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd),
        .seg_data(seg_data), .seg_sel(seg_sel)
    );

    product_bcd_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .done_flag(done_flag), .d_in(d_in),
        .busy(busy0), .bcd_valid(bcd_valid0), .bcd(bcd0),
        .seg_data(seg_data0), .seg_sel(seg_sel0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int i, input bit blz);
        if (blz && i > 0 && v < 10 ** i) return 8'hFF;
        return pat[(v / (10 ** i)) % 10];
    endfunction

    task automatic run_conv(input string tag, input logic [15:0] v);
        int  k;
        bit  busy_ok;
        d_in = v;
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        busy_ok = 1'b1;
        k = 0;
        while (!bcd_valid && k < 40) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            k++;
        end
        check({tag, "_latency"}, k, 32'd16);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(int'(v))));
        check({tag, "_bcd_lz0"}, 32'(bcd0), 32'(to_bcd(int'(v))));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_valid_pulse"}, 32'(bcd_valid), 32'd0);
    endtask

    task automatic check_scan(input string tag, input int v);
        logic [4:0] seen;
        int idx;
        int idx0;
        seen = '0;
        for (int c = 0; c < 24; c++) begin
            tick();
            check({tag, "_onehot"}, 32'($countones(~seg_sel)), 32'd1);
            check({tag, "_onehot_lz0"}, 32'($countones(~seg_sel0)), 32'd1);
            idx = 0;
            idx0 = 0;
            for (int i = 0; i < 5; i++) begin
                if (!seg_sel[i]) idx = i;
                if (!seg_sel0[i]) idx0 = i;
            end
            seen[idx] = 1'b1;
            check({tag, "_seg"}, 32'(seg_data), 32'(exp_seg(v, idx, 1'b1)));
            check({tag, "_seg_lz0"}, 32'(seg_data0), 32'(exp_seg(v, idx0, 1'b0)));
        end
        check({tag, "_all_digits"}, 32'(seen), 32'h1F);
    endtask

    initial begin
        int pulses;
        int t_first;
        int t_second;
        logic [19:0] res [$];
        int a;
        int b;

        // Reset state
        repeat (3) tick();
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_sel", 32'(seg_sel), 32'h1F);
        check("rst_seg", 32'(seg_data), 32'hFF);

        // First scan wrap occurs on the 4th edge after release
        rst = 1'b1;
        repeat (3) tick();
        check("pre_wrap_sel", 32'(seg_sel), 32'h1F);
        check("pre_wrap_seg", 32'(seg_data), 32'hFF);
        tick();
        check("first_wrap_sel", 32'(seg_sel), 32'h1E);
        check("first_wrap_seg", 32'(seg_data), 32'hC0);
        check_scan("scan_zero", 0);

        // Full-scale product
        run_conv("ffff", 16'hFFFF);
        repeat (4) tick();
        check_scan("scan_ffff", 65535);

        // 15 x 15 with leading zeros
        run_conv("e1", 16'h00E1);
        repeat (4) tick();
        check_scan("scan_e1", 225);

        // done_flag held high: exactly one conversion
        d_in = 16'd1000;
        done_flag = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bcd_valid) pulses++;
        end
        done_flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bcd_valid) pulses++;
        end
        check("held_pulses", pulses, 32'd1);
        check("held_bcd", 32'(bcd), 32'h01000);

        // Pending request mid-conversion, plus a dropped third edge
        d_in = 16'd9;
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        repeat (4) tick();
        done_flag = 1'b1;
        d_in = 16'd4096;
        tick();
        done_flag = 1'b0;
        repeat (3) tick();
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        t_first = -1;
        t_second = -1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bcd_valid) begin
                res.push_back(bcd);
                if (t_first < 0) t_first = c;
                else if (t_second < 0) t_second = c;
            end
        end
        check("pend_count", res.size(), 32'd2);
        if (res.size() >= 2) begin
            check("pend_first", 32'(res[0]), 32'(to_bcd(9)));
            check("pend_second", 32'(res[1]), 32'(to_bcd(4096)));
            check("pend_gap", t_second - t_first, 32'd17);
        end

        // Randomized products of 8-bit operands
        for (int r = 0; r < 8; r++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_conv("rand", 16'(a * b));
        end
        repeat (4) tick();
        check_scan("scan_rand", a * b);

        // Reset mid-conversion aborts and clears the result
        d_in = 16'd12345;
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        repeat (8) tick();
        #2;
        rst = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(bcd_valid), 32'd0);
        check("abort_sel", 32'(seg_sel), 32'h1F);
        tick();
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bcd_valid) pulses++;
        end
        check("abort_no_valid", pulses, 32'd0);
        check("abort_bcd_hold", 32'(bcd), 32'd0);
        run_conv("after_abort", 16'd12345);
        repeat (4) tick();
        check_scan("scan_12345", 12345);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
